// File: rtl/pulse_train_receiver_pkg.sv
// Shared types and defaults for the pulse-train receiver.
package pulse_rx_pkg;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_e;

  localparam int CNT_W_DEF        = 3;
  localparam int IDLE_TIMEOUT_DEF = 8;
  localparam int MAX_HIGH_DEF     = 4;

  // la_data_out field positions for the default CNT_W
  localparam int CNT_LSB = 0;
  localparam int VALID   = CNT_W_DEF;
  localparam int OVF     = CNT_W_DEF + 1;
  localparam int ERR     = CNT_W_DEF + 2;

endpackage

// File: rtl/pulse_train_receiver_if.sv
// Pad and logic-analyzer signals of the pulse-train receiver.
interface pulse_train_receiver_if
  import pulse_rx_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             io_in;
  logic             io_oeb;
  logic [1:0]       la_data_in;
  logic [1:0]       la_oenb;
  logic [CNT_W+2:0] la_data_out;

  modport master (output io_in, la_data_in, la_oenb, input io_oeb, la_data_out);
  modport slave  (input io_in, la_data_in, la_oenb, output io_oeb, la_data_out);
endinterface

// File: rtl/pulse_train_receiver_sync_edge_detect.sv
// Optional N-flop synchroniser followed by a delay flop for rising-edge detect.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);
  logic dly_q;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign level_o = d_i;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) sync_q <= '0;
      else       sync_q <= SYNC_STAGES'({sync_q, d_i});
    end
    assign level_o = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) dly_q <= 1'b0;
    else       dly_q <= level_o;
  end

  assign rise_o = level_o & ~dly_q;
endmodule

// File: rtl/pulse_train_receiver.sv
// Counts rising edges of io_in per burst and publishes the count on la_data_out.
// Define PULSE_ERR_EN to flag over-long high levels in the err bit.
module pulse_train_receiver
  import pulse_rx_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
  parameter int MAX_HIGH     = MAX_HIGH_DEF
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  pulse_train_receiver_if.slave bus
);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [CNT_W+2:0] res_q, res_d;

  logic pin_lvl, pin_rise, ack_raw, ack_rise, ack_lvl_unused, en, err_set;

  assign en      = bus.la_oenb[1] | bus.la_data_in[1];
  assign ack_raw = bus.la_data_in[0] & ~bus.la_oenb[0];

  sync_edge_detect #(.SYNC_STAGES(2)) u_pin (
    .clk_i(wb_clk_i), .rst_i(wb_rst_i), .d_i(bus.io_in),
    .level_o(pin_lvl), .rise_o(pin_rise)
  );

  sync_edge_detect #(.SYNC_STAGES(0)) u_ack (
    .clk_i(wb_clk_i), .rst_i(wb_rst_i), .d_i(ack_raw),
    .level_o(ack_lvl_unused), .rise_o(ack_rise)
  );

`ifdef PULSE_ERR_EN
  localparam int HR_W = $clog2(MAX_HIGH + 1);
  logic [HR_W-1:0] hr_q;

  // length of the current high run on the synchronised pin, saturating
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                      hr_q <= '0;
    else if (!pin_lvl)                 hr_q <= '0;
    else if (hr_q != HR_W'(MAX_HIGH))  hr_q <= hr_q + 1'b1;
  end

  assign err_set = pin_lvl && (hr_q >= HR_W'(MAX_HIGH));
`else
  localparam int max_high_unused = MAX_HIGH;
  logic pin_lvl_unused;
  assign pin_lvl_unused = pin_lvl;
  assign err_set        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    idle_d  = idle_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        ovf_d  = 1'b0;
        err_d  = 1'b0;
        idle_d = '0;
        if (pin_rise && en) begin
          state_d = COUNT;
          cnt_d   = CNT_W'(1);
        end
      end
      COUNT: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          idle_d  = '0;
        end else begin
          err_d = err_q | err_set;
          if (pin_rise) begin
            idle_d = '0;
            if (cnt_q == '1) ovf_d = 1'b1;
            else             cnt_d = cnt_q + 1'b1;
          end else if (idle_q == IDLE_W'(IDLE_TIMEOUT - 1)) begin
            state_d = DONE;
            res_d   = {err_d, ovf_q, 1'b1, cnt_q};
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      DONE: begin
        // ack takes priority; pin edges are ignored while a result is held
        if (ack_rise) begin
          state_d = IDLE;
          res_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      idle_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      idle_q  <= idle_d;
      res_q   <= res_d;
    end
  end

  assign bus.la_data_out = res_q;
  assign bus.io_oeb      = 1'b1;
endmodule

// File: doc/pulse_train_receiver.md
Name: pulse_train_receiver

Overview:
- Receiving end of the io_out pulse train produced by the pulse generator.
- Synchronises a single-bit pulse input and counts rising edges within a burst.
- Declares the burst finished after IDLE_TIMEOUT quiet cycles, then latches the count to the logic-analyzer bus with a valid flag until software acknowledges.
- Sits in the user project beside the generator; loopback io_out -> io_in gives self-test.

Parameters:
- CNT_W, 3, width of pulse count; saturates at 2^CNT_W-1.
- IDLE_TIMEOUT, 8, quiet cycles (no rising edge) that end a burst; legal range 2..255.
- MAX_HIGH, 4, longest legal high level in cycles; used only with PULSE_ERR_EN.

Ports:
- wb_clk_i  in  1  clock; all logic on posedge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- io_in  in  1  asynchronous pulse-train input.
- io_oeb  out  1  pad output-enable, active-low; constant 1 (input only).
- la_data_in  in  2  [0] ack (rising edge clears result), [1] enable.
- la_oenb  in  2  per-bit LA enable, active-low; bit=0 means la_data_in bit is driven and used.
- la_data_out  out  CNT_W+3  {err, ovf, valid, count[CNT_W-1:0]}.

Behaviour:
- Reset (async assert, sync release): state=IDLE, all syncs/counters 0; la_data_out=0; io_oeb=1.
- io_in: 2-flop synchroniser plus a delay flop; rise = sync & ~delayed. Pin rising edge registered in count 3 cycles later.
- Enable: en = la_oenb[1] ? 1 : la_data_in[1]. Ack: rising edge of (la_data_in[0] & ~la_oenb[0]), one registered stage.
- IDLE: count=0, idle_cnt=0, valid=0. rise & en -> COUNT, count=1.
- COUNT:
  - On rise: idle_cnt=0; count+1, saturating at 2^CNT_W-1. Rise while saturated sets ovf.
  - No rise: idle_cnt+1. When idle_cnt==IDLE_TIMEOUT-1 -> DONE; latch count/ovf/err to output register, valid=1 the following cycle.
  - en low -> IDLE immediately; partial count discarded, output register untouched.
- DONE: output held stable; further rises ignored.
  - ack -> IDLE; valid=0 the next cycle; output count/ovf/err cleared simultaneously.
  - Ack and rise in the same cycle: ack wins, rise discarded.
- Ack outside DONE: no effect.
- A generator burst (1 cycle high, 1 low) has a 1-cycle gap < IDLE_TIMEOUT, so it is one burst.
- Reset mid-operation: everything returns to reset values; no partial result is published.

Optional Feature:
- Macro PULSE_ERR_EN.
- Defined: high-run counter (saturating, reset on low). If the synchronised input stays high more than MAX_HIGH consecutive cycles during COUNT, set sticky err, published with the result and cleared by ack or reset. The counter is cleared by reset.
- Undefined: no high-run counter; err bit tied 0; port width unchanged.

Decomposition:
- Package pulse_rx_pkg:
  - state enum {IDLE, COUNT, DONE}
  - default CNT_W/IDLE_TIMEOUT/MAX_HIGH constants
  - la_data_out bit-index constants: ERR, OVF, VALID, CNT_LSB
- Sub-module sync_edge_detect: 2-flop sync + rising-edge pulse, async active-high reset.
  - Instantiated for io_in.
  - Instantiated for the ack bit without synchroniser stages (parameter SYNC_STAGES=0).

Test Plan:
- Reset, then 3 pulses (1 high/1 low) on io_in -> valid=1, count=3, ovf=0, within 3+IDLE_TIMEOUT+1 cycles of last rise.
- 9 pulses with CNT_W=3 -> count=7, ovf=1; ack -> next cycle la_data_out=0, state IDLE.
- Burst of 2, gap of 4 cycles, burst of 2 (IDLE_TIMEOUT=8) -> single result count=4; repeat with gap 12 -> first result count=2, second burst ignored until ack.
- la_oenb[1]=0, la_data_in[1]=0, pulses applied -> no valid; drop enable mid-burst -> returns IDLE, no result.
- Assert wb_rst_i asynchronously mid-COUNT -> la_data_out=0 immediately; next burst of 5 -> count=5.
- With PULSE_ERR_EN: io_in high for 6 cycles, MAX_HIGH=4 -> result count=1, err=1; without macro err=0.
